mem_access: RTL
===============

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter: DATA_W, 32, data and address width; only 32 is supported.
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 ex_valid  in  1  EX stage presents an instruction this cycle.
REQ-005 ex_op  in  8  operation code (shared EXE_*_OP encoding).
REQ-006 ex_addr  in  32  effective address (EX result y = base+offset).
REQ-007 ex_wdata  in  32  store data (rt value).
REQ-008 flush  in  1  pipeline flush (exception/eret).
REQ-009 sram_req  out  1  data SRAM request.
REQ-010 sram_wr  out  1  1 = store, 0 = load.
REQ-011 sram_size  out  2  0 = byte, 1 = half, 2 = word.
REQ-012 sram_addr  out  32  request address, passed unmodified.
REQ-013 sram_wstrb  out  4  byte write enables.
REQ-014 sram_wdata  out  32  lane-aligned store data.
REQ-015 sram_addr_ok  in  1  request accepted this cycle.
REQ-016 sram_data_ok  in  1  response (read data or write ack) this cycle.
REQ-017 sram_rdata  in  32  read data, valid with sram_data_ok.
REQ-018 mem_stall  out  1  hold upstream pipeline.
REQ-019 res_valid  out  1  load result or store completion, one-cycle pulse.
REQ-020 res_data  out  32  extended load result; 0 for stores.
REQ-021 adel  out  1  load address error, one-cycle pulse.
REQ-022 ades  out  1  store address error, one-cycle pulse.
REQ-023 badvaddr  out  32  faulting address, valid with adel/ades.

Function
REQ-024 Memory ops SHALL be LW, LH, LHU, LB, LBU, SW, SH, SB; any other op or ex_valid=0 SHALL produce no request and no stall.
REQ-025 FSM states SHALL be IDLE, ADDR, DATA, DISCARD.
REQ-026 IDLE: a memory op with an aligned address SHALL drive sram_req=1 combinationally in the same cycle; it moves to ADDR on no addr_ok, or to DATA on addr_ok.
REQ-027 ADDR: sram_req and all request fields SHALL remain stable, taken from internal registers captured on entry; it moves to DATA on addr_ok.
REQ-028 DATA: sram_req=0; on data_ok it SHALL assert res_valid and res_data in the same cycle and return to IDLE.
REQ-029 mem_stall SHALL be 1 from the accept cycle through every cycle before the data_ok cycle; it SHALL be 0 in the data_ok cycle, giving a minimum latency of 1 cycle (addr_ok and data_ok in consecutive cycles).
REQ-030 Alignment: LW needs addr[1:0]=0; LH/LHU need addr[0]=0.
REQ-031 On misalignment the block SHALL issue no request and pulse adel (loads) or ades (stores) with badvaddr=ex_addr in the same cycle, with no stall.
REQ-032 Load extension: LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; LB/LH sign-extend and LBU/LHU zero-extend.
REQ-033 Store alignment: SB wstrb=0001<<addr[1:0] and wdata={4{byte}}; SH wstrb=0011<<addr[1:0] and wdata={2{half}}; SW wstrb=1111.
REQ-034 For loads, wstrb SHALL be 0000.
REQ-035 Flush in ADDR without addr_ok: drop sram_req the next cycle and go to IDLE.
REQ-036 Flush in ADDR with addr_ok, or flush in DATA without data_ok: go to DISCARD.
REQ-037 Flush in DATA with data_ok: suppress res_valid and go to IDLE.
REQ-038 DISCARD: wait for data_ok, suppress res_valid, then go to IDLE.
REQ-039 A new memory op arriving while in DISCARD SHALL see mem_stall=1 and SHALL NOT issue until IDLE.
REQ-040 Flush in IDLE SHALL block any same-cycle request and exceptions.
REQ-041 At most one outstanding transaction SHALL exist at any time.

Reset
REQ-042 rst SHALL force state to IDLE.
REQ-043 In the reset cycle and the cycle after, all outputs SHALL be 0.
REQ-044 rst mid-transaction SHALL abandon the transaction; the SRAM side is reset together with this block.

Structure
REQ-045 EXE_*_OP codes and the sram_size encodings SHALL live in the shared defines package.
REQ-046 FSM state encoding SHALL be local to the module.
REQ-047 One combinational sub-module, mem_align (store lane/strobe generation and load extraction/extension), is natural.

Verification
REQ-048 LW addr 0x100, addr_ok next cycle, data_ok following cycle, rdata 0xDEADBEEF -> res_data 0xDEADBEEF; mem_stall high for exactly 2 cycles.
REQ-049 LB addr 0x103 with rdata 0x80112233 -> res_data 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-050 SH addr 0x202, wdata 0x1234ABCD -> wstrb 1100, sram_wdata 0xABCDABCD, size 1.
REQ-051 LW addr 0x101 -> adel pulse, badvaddr 0x101, no sram_req, mem_stall 0; SH addr 0x3 -> ades.
REQ-052 Flush asserted one cycle after addr_ok while in DATA -> DISCARD; data_ok 3 cycles later yields no res_valid; a following LW then issues normally.
REQ-053 addr_ok held low for 5 cycles -> sram_addr, wstrb and wdata stable throughout; rst mid-wait -> IDLE with all outputs 0.

Source files
------------

// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared defines for the memory-access stage: EX-stage operation
//               codes for loads/stores, data-SRAM size encodings and small
//               decode helpers used by mem_access and mem_align.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    // Load/store operation codes (shared EXE_*_OP encoding)
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    // Data SRAM transfer size encodings
    localparam logic [1:0] c_size_byte = 2'd0;
    localparam logic [1:0] c_size_half = 2'd1;
    localparam logic [1:0] c_size_word = 2'd2;

    // True for any of the eight supported load/store operations
    function automatic logic is_mem_op(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP,
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: is_mem_op = 1'b1;
            default:                         is_mem_op = 1'b0;
        endcase
    endfunction

    // True for the five load operations
    function automatic logic is_load_op(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LH_OP, EXE_LW_OP,
            EXE_LBU_OP, EXE_LHU_OP: is_load_op = 1'b1;
            default:                is_load_op = 1'b0;
        endcase
    endfunction

endpackage : mem_access_pkg
`default_nettype wire

// File: rtl/mem_access_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_align
// Description : Purely combinational lane logic for the memory-access stage.
//               Decodes the operation, checks natural alignment, builds the
//               store byte strobes / replicated store data and extracts and
//               sign- or zero-extends the load result from the read word.
// Ports       : i_op        operation code (EXE_*_OP)
//               i_addr_lo   address bits [1:0]
//               i_st_data   store source data (rt)
//               i_rdata     raw SRAM read word
//               o_is_mem    op is a supported load/store
//               o_is_load   op is a load
//               o_misalign  address violates natural alignment for the op
//               o_size      SRAM transfer size
//               o_wstrb     byte write enables (0000 for loads)
//               o_wdata     lane-replicated store data (0 for loads)
//               o_ld_data   extended load result (0 for non-loads)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_align
    import mem_access_pkg::*;
(
    input  logic [7:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_st_data,
    input  logic [31:0] i_rdata,
    output logic        o_is_mem,
    output logic        o_is_load,
    output logic        o_misalign,
    output logic [1:0]  o_size,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte and halfword lanes addressed by the low address bits
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_is_mem   = is_mem_op(i_op);
        o_is_load  = is_load_op(i_op);
        o_misalign = 1'b0;
        o_size     = c_size_word;
        o_wstrb    = 4'b0000;
        o_wdata    = 32'h0;
        o_ld_data  = 32'h0;
        case (i_op)
            EXE_LB_OP: begin
                o_size    = c_size_byte;
                o_ld_data = {{24{w_byte[7]}}, w_byte};
            end
            EXE_LBU_OP: begin
                o_size    = c_size_byte;
                o_ld_data = {24'h0, w_byte};
            end
            EXE_LH_OP: begin
                o_size     = c_size_half;
                o_misalign = i_addr_lo[0];
                o_ld_data  = {{16{w_half[15]}}, w_half};
            end
            EXE_LHU_OP: begin
                o_size     = c_size_half;
                o_misalign = i_addr_lo[0];
                o_ld_data  = {16'h0, w_half};
            end
            EXE_LW_OP: begin
                o_size     = c_size_word;
                o_misalign = |i_addr_lo;
                o_ld_data  = i_rdata;
            end
            EXE_SB_OP: begin
                o_size  = c_size_byte;
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_st_data[7:0]}};
            end
            EXE_SH_OP: begin
                o_size     = c_size_half;
                o_misalign = i_addr_lo[0];
                o_wstrb    = 4'b0011 << i_addr_lo;
                o_wdata    = {2{i_st_data[15:0]}};
            end
            EXE_SW_OP: begin
                o_size     = c_size_word;
                o_misalign = |i_addr_lo;
                o_wstrb    = 4'b1111;
                o_wdata    = i_st_data;
            end
            default: begin
                o_size = c_size_word;
            end
        endcase
    end

endmodule : mem_align
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : Memory-access stage bridging the EX stage to a data SRAM with
//               a request/addr_ok/data_ok handshake. One outstanding
//               transaction at most; misaligned accesses raise adel/ades
//               without touching the SRAM; flushes abandon or drain the
//               transaction in flight.
// Ports       : clk, rst                      clock, synchronous active-high reset
//               ex_valid/ex_op/ex_addr/ex_wdata  instruction from EX
//               flush                         pipeline flush
//               sram_req/wr/size/addr/wstrb/wdata  SRAM request channel
//               sram_addr_ok/data_ok/rdata    SRAM handshake and read data
//               mem_stall                     hold upstream pipeline
//               res_valid/res_data            completion pulse and load result
//               adel/ades/badvaddr            address-error pulses and address
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [7:0]        ex_op,
    input  logic [DATA_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              flush,
    output logic              sram_req,
    output logic              sram_wr,
    output logic [1:0]        sram_size,
    output logic [DATA_W-1:0] sram_addr,
    output logic [3:0]        sram_wstrb,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic              sram_addr_ok,
    input  logic              sram_data_ok,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              mem_stall,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              adel,
    output logic              ades,
    output logic [DATA_W-1:0] badvaddr
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_addr    = 2'd1;
    localparam logic [1:0] c_st_data    = 2'd2;
    localparam logic [1:0] c_st_discard = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              w_capture;

    // Request captured when leaving IDLE; drives ADDR-phase fields and the
    // load extraction in DATA.
    logic [7:0]        r_op;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    // Set for the first cycle after reset so that an instruction already
    // sitting in EX cannot issue before the SRAM side is out of reset too.
    logic              r_rst_q;

    logic              w_idle;
    logic [7:0]        w_sel_op;
    logic [DATA_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    logic              w_is_mem;
    logic              w_is_load;
    logic              w_misalign;
    logic [1:0]        w_size;
    logic [3:0]        w_wstrb;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_ld_data;

    // In IDLE the request is built straight from EX so it can go out in the
    // same cycle; afterwards it is rebuilt from the captured copy.
    assign w_idle      = (r_state == c_st_idle);
    assign w_sel_op    = w_idle ? ex_op    : r_op;
    assign w_sel_addr  = w_idle ? ex_addr  : r_addr;
    assign w_sel_wdata = w_idle ? ex_wdata : r_wdata;

    mem_align u_mem_align (
        .i_op       (w_sel_op),
        .i_addr_lo  (w_sel_addr[1:0]),
        .i_st_data  (w_sel_wdata),
        .i_rdata    (sram_rdata),
        .o_is_mem   (w_is_mem),
        .o_is_load  (w_is_load),
        .o_misalign (w_misalign),
        .o_size     (w_size),
        .o_wstrb    (w_wstrb),
        .o_wdata    (w_wdata),
        .o_ld_data  (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_rst_q <= 1'b1;
            r_op    <= 8'h0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next_state;
            r_rst_q <= 1'b0;
            if (w_capture) begin
                r_op    <= ex_op;
                r_addr  <= ex_addr;
                r_wdata <= ex_wdata;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        sram_req     = 1'b0;
        sram_wr      = 1'b0;
        sram_size    = 2'd0;
        sram_addr    = '0;
        sram_wstrb   = 4'b0000;
        sram_wdata   = '0;
        mem_stall    = 1'b0;
        res_valid    = 1'b0;
        res_data     = '0;
        adel         = 1'b0;
        ades         = 1'b0;
        badvaddr     = '0;

        case (r_state)
            c_st_idle: begin
                // Flush squashes both the request and any address error
                if (ex_valid && w_is_mem && !flush && !r_rst_q) begin
                    if (w_misalign) begin
                        adel     = w_is_load;
                        ades     = !w_is_load;
                        badvaddr = ex_addr;
                    end else begin
                        sram_req     = 1'b1;
                        mem_stall    = 1'b1;
                        w_capture    = 1'b1;
                        w_next_state = sram_addr_ok ? c_st_data : c_st_addr;
                    end
                end
            end

            c_st_addr: begin
                sram_req  = 1'b1;
                mem_stall = 1'b1;
                if (flush) begin
                    // Once accepted the SRAM owes a response that must be drained
                    w_next_state = sram_addr_ok ? c_st_discard : c_st_idle;
                end else if (sram_addr_ok) begin
                    w_next_state = c_st_data;
                end
            end

            c_st_data: begin
                if (sram_data_ok) begin
                    w_next_state = c_st_idle;
                    if (!flush) begin
                        res_valid = 1'b1;
                        res_data  = w_ld_data;
                    end
                end else begin
                    mem_stall = 1'b1;
                    if (flush) begin
                        w_next_state = c_st_discard;
                    end
                end
            end

            c_st_discard: begin
                // Hold a waiting load/store until the stale response is gone
                mem_stall = ex_valid && is_mem_op(ex_op);
                if (sram_data_ok) begin
                    w_next_state = c_st_idle;
                end
            end

            default: begin
                w_next_state = c_st_idle;
            end
        endcase

        if (sram_req) begin
            sram_wr    = !w_is_load;
            sram_size  = w_size;
            sram_addr  = w_sel_addr;
            sram_wstrb = w_wstrb;
            sram_wdata = w_wdata;
        end

        // All outputs are quiet while reset is asserted
        if (rst) begin
            w_capture  = 1'b0;
            sram_req   = 1'b0;
            sram_wr    = 1'b0;
            sram_size  = 2'd0;
            sram_addr  = '0;
            sram_wstrb = 4'b0000;
            sram_wdata = '0;
            mem_stall  = 1'b0;
            res_valid  = 1'b0;
            res_data   = '0;
            adel       = 1'b0;
            ades       = 1'b0;
            badvaddr   = '0;
        end
    end

endmodule : mem_access
`default_nettype wire
